// File: rtl/uart_status_tx.sv
// Frame encoder for the return direction of the host<->FPGA UART control link.
// Reports the active scaler configuration to the host as 0xAA 0x55 framed messages.
module uart_status_tx #(
    parameter logic [7:0] HDR0        = 8'hAA,
    parameter logic [7:0] HDR1        = 8'h55,
    parameter int         BUSY_WAIT   = 16,
    parameter bit         AUTO_REPORT = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [11:0] x_pix_len,
    input  logic [11:0] y_pix_len,
    input  logic        pix_len_update,
    input  logic        vid_format,
    input  logic [1:0]  algorithm,
    input  logic [8:0]  bi_a,
    input  logic        report_req,
    input  logic        tx_busy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(BUSY_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT - 1);

    localparam logic [1:0] FT_RES = 2'd0;
    localparam logic [1:0] FT_VID = 2'd1;
    localparam logic [1:0] FT_ALG = 2'd2;
    localparam logic [1:0] FT_BIA = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       flags_r;
    logic [3:0]       set_s;
    logic [3:0]       clr_s;
    logic [1:0]       sel_r;
    logic [1:0]       sel_nxt_s;
    logic [2:0]       byte_idx_r;
    logic [2:0]       byte_idx_nxt_s;
    logic [2:0]       last_idx_r;
    logic [CNT_W-1:0] busy_cnt_r;
    logic [CNT_W-1:0] busy_cnt_nxt_s;
    logic [7:0]       buf_r [0:7];
    logic             load_s;
    logic             tx_en_nxt_s;
    logic             frame_done_nxt_s;
    logic             vid_shadow_r;
    logic [1:0]       alg_shadow_r;
    logic [8:0]       bia_shadow_r;
    logic             tx_en_r;
    logic [7:0]       tx_data_r;
    logic             frame_busy_r;
    logic             frame_done_r;

    // Fixed-priority pick among pending frames: RES > VID > ALG > BIA.
    function automatic logic [1:0] pick_frame(input logic [3:0] f);
        if (f[0]) begin
            return FT_RES;
        end else if (f[1]) begin
            return FT_VID;
        end else if (f[2]) begin
            return FT_ALG;
        end else begin
            return FT_BIA;
        end
    endfunction

    // Trigger sources for each pending flag.
    always_comb begin
        set_s    = 4'b0000;
        set_s[0] = (AUTO_REPORT & pix_len_update) | report_req;
        set_s[1] = (AUTO_REPORT & (vid_format != vid_shadow_r)) | report_req;
        set_s[2] = (AUTO_REPORT & (algorithm != alg_shadow_r)) | report_req;
        set_s[3] = (AUTO_REPORT & (bi_a != bia_shadow_r)) | report_req;
        clr_s    = load_s ? (4'b0001 << sel_r) : 4'b0000;
    end

    // Shadow copies of the last seen configuration; reset values equal the parser's.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vid_shadow_r <= 1'b0;
            alg_shadow_r <= 2'd0;
            bia_shadow_r <= 9'd128;
        end else begin
            vid_shadow_r <= vid_format;
            alg_shadow_r <= algorithm;
            bia_shadow_r <= bi_a;
        end
    end

    // Pending flags; a same-cycle set beats the LOAD clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            flags_r <= 4'b0000;
        end else begin
            flags_r <= (flags_r & ~clr_s) | set_s;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_nxt_s      = state_r;
        sel_nxt_s        = sel_r;
        byte_idx_nxt_s   = byte_idx_r;
        busy_cnt_nxt_s   = busy_cnt_r;
        load_s           = 1'b0;
        tx_en_nxt_s      = 1'b0;
        frame_done_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|flags_r) begin
                    sel_nxt_s   = pick_frame(flags_r);
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s         = 1'b1;
                byte_idx_nxt_s = 3'd0;
                state_nxt_s    = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_en_nxt_s    = 1'b1;
                    busy_cnt_nxt_s = '0;
                    state_nxt_s    = ST_WAIT_BUSY;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_WAIT_BUSY: begin
                // A UART that never raises busy still lets the byte count as accepted.
                if (tx_busy || (busy_cnt_r == CNT_LAST)) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    busy_cnt_nxt_s = busy_cnt_r + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (byte_idx_r == last_idx_r) begin
                        frame_done_nxt_s = 1'b1;
                        state_nxt_s      = ST_IDLE;
                    end else begin
                        byte_idx_nxt_s = byte_idx_r + 3'd1;
                        state_nxt_s    = ST_SEND;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM and bookkeeping registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            sel_r      <= 2'd0;
            byte_idx_r <= 3'd0;
            busy_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            sel_r      <= sel_nxt_s;
            byte_idx_r <= byte_idx_nxt_s;
            busy_cnt_r <= busy_cnt_nxt_s;
        end
    end

    // Frame buffer: payload is frozen here so later input changes cannot reach bytes in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 8; i++) begin
                buf_r[i] <= 8'h00;
            end
            last_idx_r <= 3'd0;
        end else if (load_s) begin
            buf_r[0] <= HDR0;
            buf_r[1] <= HDR1;
            for (int i = 2; i < 8; i++) begin
                buf_r[i] <= 8'h00;
            end
            case (sel_r)
                FT_RES: begin
                    buf_r[2]   <= {4'h0, x_pix_len[11:8]};
                    buf_r[3]   <= x_pix_len[7:0];
                    buf_r[4]   <= {4'h0, y_pix_len[11:8]};
                    buf_r[5]   <= y_pix_len[7:0];
                    last_idx_r <= 3'd5;
                end
                FT_VID: begin
                    buf_r[2]   <= 8'hCF;
                    buf_r[3]   <= {7'b0, vid_format};
                    last_idx_r <= 3'd3;
                end
                FT_ALG: begin
                    buf_r[2]   <= 8'h3F;
                    buf_r[3]   <= {6'b0, algorithm};
                    last_idx_r <= 3'd3;
                end
                default: begin
                    buf_r[2]   <= 8'hAF;
                    buf_r[3]   <= {7'b0, bi_a[8]};
                    buf_r[4]   <= bi_a[7:0];
                    last_idx_r <= 3'd4;
                end
            endcase
        end else begin
            last_idx_r <= last_idx_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_en_r      <= 1'b0;
            tx_data_r    <= 8'h00;
            frame_busy_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            tx_en_r      <= tx_en_nxt_s;
            frame_busy_r <= (state_nxt_s != ST_IDLE);
            frame_done_r <= frame_done_nxt_s;
            if (tx_en_nxt_s) begin
                tx_data_r <= buf_r[byte_idx_r];
            end else begin
                tx_data_r <= tx_data_r;
            end
        end
    end

    assign tx_en      = tx_en_r;
    assign tx_data    = tx_data_r;
    assign frame_busy = frame_busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_uart_status_tx.sv
// Self-checking bench for uart_status_tx: vector table, hand-written corner sequences
// and randomized configuration changes checked against a frame-level reference model.
module tb_uart_status_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [11:0] x_pix_len;
    logic [11:0] y_pix_len;
    logic        pix_len_update;
    logic        vid_format;
    logic [1:0]  algorithm;
    logic [8:0]  bi_a;
    logic        report_req;
    logic        tx_busy = 1'b0;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        frame_busy;
    logic        frame_done;

    uart_status_tx dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .x_pix_len      (x_pix_len),
        .y_pix_len      (y_pix_len),
        .pix_len_update (pix_len_update),
        .vid_format     (vid_format),
        .algorithm      (algorithm),
        .bi_a           (bi_a),
        .report_req     (report_req),
        .tx_busy        (tx_busy),
        .tx_en          (tx_en),
        .tx_data        (tx_data),
        .frame_busy     (frame_busy),
        .frame_done     (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int pcyc = 0;
    logic [7:0] got_q[$];
    int         en_cyc_q[$];
    logic [7:0] exp_q[$];
    int done_cnt = 0;
    int viol = 0;
    int busy_left = 0;
    int busy_len = 3;
    bit dead = 1'b0;

    always @(posedge sys_clk) pcyc <= pcyc + 1;

    // Byte UART model: records every accepted byte and holds busy for busy_len cycles.
    always @(negedge sys_clk) begin
        if (tx_en) begin
            if (tx_busy) viol <= viol + 1;
            got_q.push_back(tx_data);
            en_cyc_q.push_back(pcyc);
            if (!dead) begin
                tx_busy   <= 1'b1;
                busy_left <= busy_len;
            end
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left <= 0;
            tx_busy   <= 1'b0;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference frame layout: header, opcode/payload bytes as the host protocol defines them.
    task automatic add_frame(input int ft, input logic [11:0] x, input logic [11:0] y,
                             input logic vid, input logic [1:0] alg, input logic [8:0] bia);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        case (ft)
            0: begin
                exp_q.push_back(8'(x / 256));
                exp_q.push_back(8'(x % 256));
                exp_q.push_back(8'(y / 256));
                exp_q.push_back(8'(y % 256));
            end
            1: begin
                exp_q.push_back(8'hCF);
                exp_q.push_back(8'(vid));
            end
            2: begin
                exp_q.push_back(8'h3F);
                exp_q.push_back(8'(alg));
            end
            default: begin
                exp_q.push_back(8'hAF);
                exp_q.push_back(8'(bia / 256));
                exp_q.push_back(8'(bia % 256));
            end
        endcase
    endtask

    task automatic drain(input string name, input int gbase, input int dbase,
                         input int t0, input int exp_frames);
        int idle = 0;
        int n = 0;
        while (idle < 8 && n < 5000) begin
            @(negedge sys_clk);
            #1;
            if (frame_busy) idle = 0;
            else idle++;
            n++;
        end
        check({name, " timeout"}, int'(n >= 5000), 0);
        check({name, " nbytes"}, got_q.size() - gbase, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (gbase + i < got_q.size())
                check($sformatf("%s byte%0d", name, i), int'(got_q[gbase+i]), int'(exp_q[i]));
        end
        check({name, " frames"}, done_cnt - dbase, exp_frames);
        if (t0 >= 0 && exp_q.size() > 0 && en_cyc_q.size() > gbase)
            check({name, " latency"}, en_cyc_q[gbase] - t0, 4);
    endtask

    task automatic run_vec(input string name, input logic [11:0] x, input logic [11:0] y,
                           input logic vid, input logic [1:0] alg, input logic [8:0] bia,
                           input logic upd, input logic req, input int exp_frames);
        int gbase;
        int dbase;
        int t0;
        gbase = got_q.size();
        dbase = done_cnt;
        @(negedge sys_clk);
        x_pix_len = x; y_pix_len = y; vid_format = vid; algorithm = alg; bi_a = bia;
        pix_len_update = upd; report_req = req;
        t0 = pcyc;
        @(negedge sys_clk);
        pix_len_update = 1'b0; report_req = 1'b0;
        drain(name, gbase, dbase, t0, exp_frames);
    endtask

    typedef struct {
        logic [11:0]  x;
        logic [11:0]  y;
        logic         vid;
        logic [1:0]   alg;
        logic [8:0]   bia;
        logic         upd;
        logic         req;
        int           nbytes;
        logic [151:0] bytes;
        int           frames;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [151:0] bv;
        logic         m_vid;
        logic [1:0]   m_alg;
        logic [8:0]   m_bia;
        logic [11:0]  nx, ny;
        logic         nv, nu, nr;
        logic [1:0]   na;
        logic [8:0]   nb;
        int           nf, gbase, dbase, t0, n, hi;

        vecs[0] = '{12'd1920, 12'd1080, 1'b0, 2'd0, 9'd128, 1'b1, 1'b0, 6,
                    {8'hAA, 8'h55, 8'h07, 8'h80, 8'h04, 8'h38, 104'h0}, 1};
        vecs[1] = '{12'd1920, 12'd1080, 1'b0, 2'd2, 9'd64, 1'b0, 1'b0, 9,
                    {8'hAA, 8'h55, 8'h3F, 8'h02, 8'hAA, 8'h55, 8'hAF, 8'h00, 8'h40, 80'h0}, 2};
        vecs[2] = '{12'd640, 12'd480, 1'b1, 2'd1, 9'd300, 1'b0, 1'b1, 19,
                    {8'hAA, 8'h55, 8'h02, 8'h80, 8'h01, 8'hE0, 8'hAA, 8'h55, 8'hCF, 8'h01,
                     8'hAA, 8'h55, 8'h3F, 8'h01, 8'hAA, 8'h55, 8'hAF, 8'h01, 8'h2C}, 4};
        vecs[3] = '{12'd640, 12'd480, 1'b0, 2'd1, 9'd300, 1'b0, 1'b0, 4,
                    {8'hAA, 8'h55, 8'hCF, 8'h00, 120'h0}, 1};
        vecs[4] = '{12'd640, 12'd480, 1'b0, 2'd1, 9'd300, 1'b0, 1'b0, 0, 152'h0, 0};

        sys_rst_n = 1'b0;
        x_pix_len = 12'd0; y_pix_len = 12'd0; pix_len_update = 1'b0;
        vid_format = 1'b0; algorithm = 2'd0; bi_a = 9'd128; report_req = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst tx_en", int'(tx_en), 0);
        check("rst tx_data", int'(tx_data), 0);
        check("rst frame_busy", int'(frame_busy), 0);
        check("rst frame_done", int'(frame_done), 0);
        sys_rst_n = 1'b1;

        // Quiet after reset with default inputs.
        gbase = got_q.size();
        hi = 0;
        repeat (100) begin
            @(negedge sys_clk);
            #1;
            if (frame_busy) hi++;
        end
        check("idle bytes", got_q.size() - gbase, 0);
        check("idle frame_busy", hi, 0);

        for (int i = 0; i < 5; i++) begin
            exp_q.delete();
            bv = vecs[i].bytes;
            for (int b = 0; b < vecs[i].nbytes; b++) exp_q.push_back(bv[151 - 8*b -: 8]);
            run_vec($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].vid, vecs[i].alg,
                    vecs[i].bia, vecs[i].upd, vecs[i].req, vecs[i].frames);
        end

        // Payload frozen mid-frame; retrigger of the frame in flight sends it again.
        exp_q.delete();
        add_frame(0, 12'd100, 12'd200, 1'b0, 2'd1, 9'd300);
        add_frame(0, 12'd300, 12'd400, 1'b0, 2'd1, 9'd300);
        gbase = got_q.size();
        dbase = done_cnt;
        @(negedge sys_clk);
        x_pix_len = 12'd100; y_pix_len = 12'd200; pix_len_update = 1'b1;
        t0 = pcyc;
        @(negedge sys_clk);
        pix_len_update = 1'b0;
        n = 0;
        while (got_q.size() - gbase < 2 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("retrig wait", int'(n < 200), 1);
        @(negedge sys_clk);
        x_pix_len = 12'd300; y_pix_len = 12'd400; pix_len_update = 1'b1;
        @(negedge sys_clk);
        pix_len_update = 1'b0;
        drain("retrig", gbase, dbase, t0, 2);

        // UART that never raises busy: each byte waits out the timeout.
        dead = 1'b1;
        exp_q.delete();
        add_frame(2, 12'd300, 12'd400, 1'b0, 2'd2, 9'd300);
        gbase = got_q.size();
        run_vec("dead", 12'd300, 12'd400, 1'b0, 2'd2, 9'd300, 1'b0, 1'b0, 1);
        for (int i = 1; i < 4; i++) begin
            if (gbase + i < en_cyc_q.size()) begin
                n = en_cyc_q[gbase+i] - en_cyc_q[gbase+i-1];
                if (n < 16 || n > 20) check($sformatf("dead spacing%0d", i), n, 18);
                else check($sformatf("dead spacing%0d", i), n, n);
            end
        end
        dead = 1'b0;

        // Randomized configuration changes against the frame-level model.
        m_vid = 1'b0; m_alg = 2'd2; m_bia = 9'd300;
        for (int it = 0; it < 30; it++) begin
            nx = 12'($urandom_range(0, 4095));
            ny = 12'($urandom_range(0, 4095));
            nv = 1'($urandom_range(0, 1));
            na = ($urandom_range(0, 1) == 0) ? m_alg : 2'($urandom_range(0, 3));
            nb = ($urandom_range(0, 1) == 0) ? m_bia : 9'($urandom_range(0, 511));
            nu = 1'($urandom_range(0, 1));
            nr = ($urandom_range(0, 3) == 0);
            busy_len = int'($urandom_range(1, 6));
            exp_q.delete();
            nf = 0;
            if (nu || nr) begin add_frame(0, nx, ny, nv, na, nb); nf++; end
            if (nv != m_vid || nr) begin add_frame(1, nx, ny, nv, na, nb); nf++; end
            if (na != m_alg || nr) begin add_frame(2, nx, ny, nv, na, nb); nf++; end
            if (nb != m_bia || nr) begin add_frame(3, nx, ny, nv, na, nb); nf++; end
            run_vec($sformatf("rnd%0d", it), nx, ny, nv, na, nb, nu, nr, nf);
            m_vid = nv; m_alg = na; m_bia = nb;
        end

        // Reset during the third byte of a RES frame abandons the frame.
        busy_len = 4;
        gbase = got_q.size();
        dbase = done_cnt;
        @(negedge sys_clk);
        x_pix_len = 12'd1920; y_pix_len = 12'd1080; pix_len_update = 1'b1;
        @(negedge sys_clk);
        pix_len_update = 1'b0;
        n = 0;
        while (got_q.size() - gbase < 3 && n < 300) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check("rst wait", int'(n < 300), 1);
        sys_rst_n = 1'b0;
        #1;
        check("midrst tx_en", int'(tx_en), 0);
        check("midrst tx_data", int'(tx_data), 0);
        check("midrst frame_busy", int'(frame_busy), 0);
        check("midrst frame_done", int'(frame_done), 0);
        vid_format = 1'b0; algorithm = 2'd0; bi_a = 9'd128;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (60) @(negedge sys_clk);
        check("midrst bytes", got_q.size() - gbase, 3);
        check("midrst frames", done_cnt - dbase, 0);

        check("tx_en while busy", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
